pa_trace_buffer: RTL and testbench
==================================

Name: pa_trace_buffer

Overview:
Parametrised on-chip trace capture for the PA-RISC pipeline. It records the committed PC and register-file writeback of each retired instruction into a circular buffer. A selectable trigger freezes a pre-trigger/post-trigger window, which is then drained through a pop handshake. It sits beside the writeback stage and replaces console-only $monitor tracing with a hardware-visible, bench-checkable record.

Parameters:
PC_WIDTH, 32, width of captured PC
DATA_WIDTH, 32, width of captured writeback data
REG_AW, 5, register index width (32 GRs)
DEPTH, 16, buffer entries; power of two, >= 4
POST_TRIG, 8, samples captured after the trigger sample; legal range 0..DEPTH-1

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
arm  in  1  single-cycle pulse; starts a capture from IDLE or DONE
trig_mode  in  2  00 immediate, 01 PC match, 10 write to trig_reg, 11 PC match AND wb_en
trig_pc  in  PC_WIDTH  PC compare value
trig_reg  in  REG_AW  register compare value
smp_valid  in  1  an instruction retires this cycle
smp_pc  in  PC_WIDTH  PC of the retiring instruction
smp_wb_en  in  1  retiring instruction writes the register file
smp_reg  in  REG_AW  destination register
smp_data  in  DATA_WIDTH  writeback value
rd_req  in  1  pop request for the oldest stored entry
rd_valid  out  1  registered; rd_* outputs are valid this cycle
rd_pc  out  PC_WIDTH  popped PC
rd_wb_en  out  1  popped wb flag
rd_reg  out  REG_AW  popped register
rd_data  out  DATA_WIDTH  popped data
count  out  clog2(DEPTH)+1  entries currently stored
state  out  2  00 IDLE, 01 ARMED, 10 POST, 11 DONE
wrapped  out  1  sticky; at least one entry was overwritten during this capture

Behaviour:
- Reset values: state=IDLE; count=0; pointers=0; rd_valid=0; rd_* data outputs=0; wrapped=0. Storage contents are don't-care.
- IDLE: smp_valid is ignored and rd_req is ignored. On arm, go to ARMED and clear count, pointers and wrapped.
- ARMED: each smp_valid cycle writes one entry at wr_ptr, and wr_ptr increments mod DEPTH.
  - If count==DEPTH, the oldest entry is overwritten: rd_ptr advances and wrapped is set.
  - Otherwise count increments.
- Trigger evaluation: only on an smp_valid cycle in ARMED, using the current sample.
  - 00: first sample fires.
  - 01: smp_pc==trig_pc.
  - 10: smp_wb_en && smp_reg==trig_reg.
  - 11: smp_pc==trig_pc && smp_wb_en.
  - The triggering sample is always stored.
  - If POST_TRIG==0, the next state is DONE. Otherwise the next state is POST and post_cnt is loaded with POST_TRIG.
- POST: each smp_valid cycle stores an entry with the same overwrite rule and decrements post_cnt. The store that takes post_cnt to 0 moves the block to DONE.
  - Because POST_TRIG<=DEPTH-1, the trigger sample is never overwritten.
- DONE: capture is frozen and smp_* is ignored.
  - rd_req with count>0: on the next cycle rd_valid=1 with the entry at rd_ptr; rd_ptr increments and count decrements.
  - rd_req with count==0: rd_valid=0 next cycle, and no pointer movement.
  - Read latency is exactly 1 cycle, and back-to-back pops are supported at 1 per cycle.
- arm asserted in ARMED or POST is ignored. arm in DONE restarts the capture and discards unread entries; it takes priority over a same-cycle rd_req, so rd_valid=0 next cycle.
- rd_valid is deasserted in every cycle that has no accepted pop.
- Reset asserted in any state, including mid-POST or mid-readout, returns every output to its reset value on the next edge.
- Widths: count saturates at DEPTH. Pointer arithmetic wraps mod DEPTH with no extra bit; count alone distinguishes full from empty.

Decomposition:
- Shared package pa_trace_pkg holds:
  - state encoding constants (ST_IDLE, ST_ARMED, ST_POST, ST_DONE);
  - trigger mode constants (TRIG_IMM, TRIG_PC, TRIG_REG, TRIG_PC_WB);
  - the packed entry layout {pc, wb_en, reg, data} with its total width.
- One sub-module: pa_trace_ram, a single-port-write / single-port-read synchronous RAM of DEPTH x entry width with a registered read. The top holds the FSM, pointers, counters and trigger compare.

Test Plan:
- Reset mid-POST: arm with mode 00, feed 3 samples, assert reset for 1 cycle -> state=00, count=0, rd_valid=0, wrapped=0 on the next edge.
- Immediate trigger, POST_TRIG=2: arm, feed PCs 0,4,8,12 -> state=11 after PC 8, count=3; three pops return 0,4,8 on consecutive cycles with rd_valid=1; a 4th pop gives rd_valid=0.
- Pre-trigger wrap, DEPTH=4, POST_TRIG=1, mode 01, trig_pc=40: feed PCs 0,4,...,44 -> wrapped=1, count=4; pops return 32,36,40,44.
- Register trigger, mode 10, trig_reg=5: write GR3=7, then GR5=0x1234 at PC 20 -> trigger fires at PC 20; the popped entry shows rd_reg=5, rd_data=0x1234, rd_wb_en=1.
- Mode 11 rejection: a sample at PC=trig_pc with smp_wb_en=0 -> no trigger and state stays 01; the same PC with wb_en=1 later -> trigger fires.
- Control corner cases, in DONE with count=2: arm and rd_req in the same cycle -> state=01, count=0, rd_valid=0. Separately, arm pulsed while in ARMED -> count continues and is not cleared.

Source files
------------

// File: rtl/pa_trace_pkg.sv
// Shared definitions for the PA-RISC retirement trace buffer: FSM states,
// trigger modes and the packed layout of one captured entry.
package pa_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_POST  = 2'b10,
        ST_DONE  = 2'b11
    } trace_state_e;

    localparam logic [1:0] TRIG_IMM   = 2'b00;
    localparam logic [1:0] TRIG_PC    = 2'b01;
    localparam logic [1:0] TRIG_REG   = 2'b10;
    localparam logic [1:0] TRIG_PC_WB = 2'b11;

    // Entry layout, MSB first: {pc, wb_en, reg, data}. The struct documents the
    // default-width layout; parametrised instances size it with entry_width().
    typedef struct packed {
        logic [31:0] pc;
        logic        wb_en;
        logic [4:0]  rgi;
        logic [31:0] data;
    } trace_entry_t;

    localparam int ENTRY_W_DEF = $bits(trace_entry_t);

    function automatic int entry_width(input int pc_w, input int reg_aw, input int data_w);
        return pc_w + 1 + reg_aw + data_w;
    endfunction

endpackage

// File: rtl/pa_trace_ram.sv
// Trace storage: one synchronous write port, one read port with a registered
// output that clears on reset so the popped fields start at zero.
module pa_trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 70
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // read stage: p0 address -> p1 data
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pa_trace_buffer.sv
// Retirement trace capture: circular pre-trigger history, a post-trigger
// window, then a frozen buffer drained one entry per rd_req.
module pa_trace_buffer
    import pa_trace_pkg::*;
#(
    parameter int PC_WIDTH   = 32,
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW     = 5,
    parameter int DEPTH      = 16,
    parameter int POST_TRIG  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arm,
    input  logic [1:0]               trig_mode,
    input  logic [PC_WIDTH-1:0]      trig_pc,
    input  logic [REG_AW-1:0]        trig_reg,
    input  logic                     smp_valid,
    input  logic [PC_WIDTH-1:0]      smp_pc,
    input  logic                     smp_wb_en,
    input  logic [REG_AW-1:0]        smp_reg,
    input  logic [DATA_WIDTH-1:0]    smp_data,
    input  logic                     rd_req,
    output logic                     rd_valid,
    output logic [PC_WIDTH-1:0]      rd_pc,
    output logic                     rd_wb_en,
    output logic [REG_AW-1:0]        rd_reg,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [1:0]               state,
    output logic                     wrapped
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = entry_width(PC_WIDTH, REG_AW, DATA_WIDTH);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [AW-1:0] POST_LD = AW'(POST_TRIG);

    trace_state_e    st_q, st_d;
    logic [AW-1:0]   wr_ptr, rd_ptr, post_cnt;
    logic [CW-1:0]   cnt;
    logic            wrapped_q;
    logic            vld_p1;
    logic            trig_hit;
    logic            do_clr, do_store, do_pop, load_post;
    logic [EW-1:0]   wr_entry, rd_entry;

    always_comb begin
        trig_hit = 1'b0;
        case (trig_mode)
            TRIG_IMM:   trig_hit = 1'b1;
            TRIG_PC:    trig_hit = (smp_pc == trig_pc);
            TRIG_REG:   trig_hit = smp_wb_en && (smp_reg == trig_reg);
            TRIG_PC_WB: trig_hit = (smp_pc == trig_pc) && smp_wb_en;
            default:    trig_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q <= ST_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d      = st_q;
        do_clr    = 1'b0;
        do_store  = 1'b0;
        do_pop    = 1'b0;
        load_post = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (arm) begin
                    st_d   = ST_ARMED;
                    do_clr = 1'b1;
                end
            end
            ST_ARMED: begin
                if (smp_valid) begin
                    do_store = 1'b1;
                    if (trig_hit) begin
                        if (POST_TRIG == 0) begin
                            st_d = ST_DONE;
                        end else begin
                            st_d      = ST_POST;
                            load_post = 1'b1;
                        end
                    end
                end
            end
            ST_POST: begin
                if (smp_valid) begin
                    do_store = 1'b1;
                    if (post_cnt == AW'(1)) begin
                        st_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // a restart discards unread entries, so it wins over a pop
                if (arm) begin
                    st_d   = ST_ARMED;
                    do_clr = 1'b1;
                end else if (rd_req && (cnt != '0)) begin
                    do_pop = 1'b1;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            post_cnt  <= '0;
            wrapped_q <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= do_pop;
            if (do_clr) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                cnt       <= '0;
                wrapped_q <= 1'b0;
            end else if (do_store) begin
                wr_ptr <= wr_ptr + AW'(1);
                // full buffer: the new sample evicts the oldest one
                if (cnt == FULL) begin
                    rd_ptr    <= rd_ptr + AW'(1);
                    wrapped_q <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                cnt    <= cnt - CW'(1);
            end
            if (load_post) begin
                post_cnt <= POST_LD;
            end else if (do_store && (st_q == ST_POST)) begin
                post_cnt <= post_cnt - AW'(1);
            end
        end
    end

    assign wr_entry = {smp_pc, smp_wb_en, smp_reg, smp_data};

    pa_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (do_store),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .re    (do_pop),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    // p1: popped entry and its valid leave together
    assign rd_valid = vld_p1;
    assign rd_pc    = rd_entry[EW-1 -: PC_WIDTH];
    assign rd_wb_en = rd_entry[DATA_WIDTH + REG_AW];
    assign rd_reg   = rd_entry[DATA_WIDTH +: REG_AW];
    assign rd_data  = rd_entry[DATA_WIDTH-1:0];
    assign count    = cnt;
    assign state    = st_q;
    assign wrapped  = wrapped_q;

endmodule

// File: tb/tb_pa_trace_buffer.sv
// Bench for pa_trace_buffer: two configurations driven by the same stimulus,
// a queue-based reference model, a vector table, directed corners and random traffic.
module tb_pa_trace_buffer;

    localparam int A_D = 16;
    localparam int A_P = 2;
    localparam int B_D = 4;
    localparam int B_P = 1;

    logic        clk = 1'b0;
    logic        reset, arm, smp_valid, smp_wb_en, rd_req;
    logic [1:0]  trig_mode;
    logic [31:0] trig_pc, smp_pc, smp_data;
    logic [4:0]  trig_reg, smp_reg;

    logic        a_rd_valid, a_rd_wb_en, a_wrapped;
    logic [31:0] a_rd_pc, a_rd_data;
    logic [4:0]  a_rd_reg, a_count;
    logic [1:0]  a_state;
    logic        b_rd_valid, b_rd_wb_en, b_wrapped;
    logic [31:0] b_rd_pc, b_rd_data;
    logic [4:0]  b_rd_reg;
    logic [2:0]  b_count;
    logic [1:0]  b_state;

    always #5 clk = ~clk;

    pa_trace_buffer #(.DEPTH(A_D), .POST_TRIG(A_P)) u_a (
        .clk(clk), .reset(reset), .arm(arm), .trig_mode(trig_mode), .trig_pc(trig_pc),
        .trig_reg(trig_reg), .smp_valid(smp_valid), .smp_pc(smp_pc), .smp_wb_en(smp_wb_en),
        .smp_reg(smp_reg), .smp_data(smp_data), .rd_req(rd_req), .rd_valid(a_rd_valid),
        .rd_pc(a_rd_pc), .rd_wb_en(a_rd_wb_en), .rd_reg(a_rd_reg), .rd_data(a_rd_data),
        .count(a_count), .state(a_state), .wrapped(a_wrapped)
    );

    pa_trace_buffer #(.DEPTH(B_D), .POST_TRIG(B_P)) u_b (
        .clk(clk), .reset(reset), .arm(arm), .trig_mode(trig_mode), .trig_pc(trig_pc),
        .trig_reg(trig_reg), .smp_valid(smp_valid), .smp_pc(smp_pc), .smp_wb_en(smp_wb_en),
        .smp_reg(smp_reg), .smp_data(smp_data), .rd_req(rd_req), .rd_valid(b_rd_valid),
        .rd_pc(b_rd_pc), .rd_wb_en(b_rd_wb_en), .rd_reg(b_rd_reg), .rd_data(b_rd_data),
        .count(b_count), .state(b_state), .wrapped(b_wrapped)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        wb;
        logic [4:0]  rg;
        logic [31:0] data;
    } ent_t;

    // Model: state 0 idle, 1 armed, 2 post, 3 done; queue front is the oldest entry.
    ent_t q0[$];
    ent_t q1[$];
    int   m_st[2];
    int   m_left[2];
    bit   m_wr[2];
    bit   m_rv[2];
    bit   m_chk[2];
    ent_t m_rd[2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit fires();
        case (trig_mode)
            2'b00:   return 1'b1;
            2'b01:   return smp_pc == trig_pc;
            2'b10:   return smp_wb_en && (smp_reg == trig_reg);
            default: return (smp_pc == trig_pc) && smp_wb_en;
        endcase
    endfunction

    task automatic model_step(input int i);
        ent_t q[$];
        ent_t e;
        int   dep, pst;
        dep = (i == 0) ? A_D : B_D;
        pst = (i == 0) ? A_P : B_P;
        if (i == 0) q = q0; else q = q1;
        e = '{smp_pc, smp_wb_en, smp_reg, smp_data};
        m_rv[i]  = 1'b0;
        m_chk[i] = 1'b0;
        if (reset) begin
            q.delete();
            m_st[i] = 0; m_wr[i] = 1'b0; m_rd[i] = '0; m_chk[i] = 1'b1;
        end else begin
            case (m_st[i])
                0: if (arm) begin q.delete(); m_wr[i] = 1'b0; m_st[i] = 1; end
                1, 2: if (smp_valid) begin
                    if (q.size() == dep) begin void'(q.pop_front()); m_wr[i] = 1'b1; end
                    q.push_back(e);
                    if (m_st[i] == 2) begin
                        m_left[i]--;
                        if (m_left[i] == 0) m_st[i] = 3;
                    end else if (fires()) begin
                        if (pst == 0) m_st[i] = 3;
                        else begin m_st[i] = 2; m_left[i] = pst; end
                    end
                end
                default: begin
                    if (arm) begin q.delete(); m_wr[i] = 1'b0; m_st[i] = 1; end
                    else if (rd_req && q.size() > 0) begin
                        m_rd[i] = q.pop_front(); m_rv[i] = 1'b1; m_chk[i] = 1'b1;
                    end
                end
            endcase
        end
        if (i == 0) q0 = q; else q1 = q;
    endtask

    task automatic check_dut();
        chk("a_state", 64'(a_state), 64'(m_st[0]));
        chk("a_count", 64'(a_count), 64'(q0.size()));
        chk("a_wrapped", 64'(a_wrapped), 64'(m_wr[0]));
        chk("a_rd_valid", 64'(a_rd_valid), 64'(m_rv[0]));
        if (m_chk[0]) chk("a_rd_entry", 64'({a_rd_pc, a_rd_wb_en, a_rd_reg}) ^ 64'(a_rd_data),
                          64'({m_rd[0].pc, m_rd[0].wb, m_rd[0].rg}) ^ 64'(m_rd[0].data));
        chk("b_state", 64'(b_state), 64'(m_st[1]));
        chk("b_count", 64'(b_count), 64'(q1.size()));
        chk("b_wrapped", 64'(b_wrapped), 64'(m_wr[1]));
        chk("b_rd_valid", 64'(b_rd_valid), 64'(m_rv[1]));
        if (m_chk[1]) chk("b_rd_entry", 64'({b_rd_pc, b_rd_wb_en, b_rd_reg}) ^ 64'(b_rd_data),
                          64'({m_rd[1].pc, m_rd[1].wb, m_rd[1].rg}) ^ 64'(m_rd[1].data));
    endtask

    task automatic cycle();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_dut();
    endtask

    task automatic do_reset();
        reset = 1'b1; cycle(); reset = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1; cycle(); arm = 1'b0;
    endtask

    task automatic smp(input logic [31:0] pc, input logic wb, input logic [4:0] rg, input logic [31:0] d);
        smp_valid = 1'b1; smp_pc = pc; smp_wb_en = wb; smp_reg = rg; smp_data = d;
        cycle();
        smp_valid = 1'b0;
    endtask

    task automatic pop();
        rd_req = 1'b1; cycle(); rd_req = 1'b0;
    endtask

    typedef struct {
        logic        arm;
        logic        sv;
        logic [31:0] pc;
        logic        rq;
        logic [1:0]  e_st;
        int          e_cnt;
        logic        e_rv;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl [9];

    initial begin
        reset = 1'b1; arm = 1'b0; smp_valid = 1'b0; smp_wb_en = 1'b0; rd_req = 1'b0;
        trig_mode = 2'b00; trig_pc = '0; trig_reg = '0; smp_pc = '0; smp_data = '0; smp_reg = '0;

        // Immediate trigger on the 16-deep/post-2 instance, applied from a table.
        tbl[0] = '{1'b1, 1'b0, 32'd0,  1'b0, 2'b01, 0, 1'b0, 32'd0};
        tbl[1] = '{1'b0, 1'b1, 32'd0,  1'b0, 2'b10, 1, 1'b0, 32'd0};
        tbl[2] = '{1'b0, 1'b1, 32'd4,  1'b0, 2'b10, 2, 1'b0, 32'd0};
        tbl[3] = '{1'b0, 1'b1, 32'd8,  1'b0, 2'b11, 3, 1'b0, 32'd0};
        tbl[4] = '{1'b0, 1'b1, 32'd12, 1'b0, 2'b11, 3, 1'b0, 32'd0};
        tbl[5] = '{1'b0, 1'b0, 32'd0,  1'b1, 2'b11, 2, 1'b1, 32'd0};
        tbl[6] = '{1'b0, 1'b0, 32'd0,  1'b1, 2'b11, 1, 1'b1, 32'd4};
        tbl[7] = '{1'b0, 1'b0, 32'd0,  1'b1, 2'b11, 0, 1'b1, 32'd8};
        tbl[8] = '{1'b0, 1'b0, 32'd0,  1'b1, 2'b11, 0, 1'b0, 32'd0};

        do_reset();
        do_reset();
        chk("reset_state", 64'(a_state), 64'd0);
        chk("reset_rd_data", 64'(a_rd_data), 64'd0);

        // Reset while the post-trigger window is still open.
        do_arm();
        smp(32'd0, 1'b0, 5'd0, 32'd0);
        smp(32'd4, 1'b0, 5'd0, 32'd0);
        chk("midpost_state_before", 64'(a_state), 64'd2);
        do_reset();
        chk("midpost_state", 64'(a_state), 64'd0);
        chk("midpost_count", 64'(a_count), 64'd0);
        chk("midpost_wrapped", 64'(b_wrapped), 64'd0);
        chk("midpost_rd_valid", 64'(a_rd_valid), 64'd0);

        for (int k = 0; k < 9; k++) begin
            arm = tbl[k].arm; smp_valid = tbl[k].sv; smp_pc = tbl[k].pc; rd_req = tbl[k].rq;
            cycle();
            chk($sformatf("tbl%0d_state", k), 64'(a_state), 64'(tbl[k].e_st));
            chk($sformatf("tbl%0d_count", k), 64'(a_count), 64'(tbl[k].e_cnt));
            chk($sformatf("tbl%0d_rd_valid", k), 64'(a_rd_valid), 64'(tbl[k].e_rv));
            if (tbl[k].e_rv) chk($sformatf("tbl%0d_rd_pc", k), 64'(a_rd_pc), 64'(tbl[k].e_pc));
        end
        arm = 1'b0; smp_valid = 1'b0; rd_req = 1'b0;

        // Pre-trigger wrap on the 4-deep/post-1 instance.
        do_reset();
        trig_mode = 2'b01; trig_pc = 32'd40;
        do_arm();
        for (int p = 0; p <= 44; p += 4) smp(32'(p), 1'b0, 5'd0, 32'(p));
        chk("wrap_wrapped", 64'(b_wrapped), 64'd1);
        chk("wrap_count", 64'(b_count), 64'd4);
        chk("wrap_state", 64'(b_state), 64'd3);
        for (int k = 0; k < 4; k++) begin
            pop();
            chk("wrap_rd_valid", 64'(b_rd_valid), 64'd1);
            chk($sformatf("wrap_pop%0d_pc", k), 64'(b_rd_pc), 64'(32 + 4 * k));
        end

        // Register-write trigger.
        do_reset();
        trig_mode = 2'b10; trig_reg = 5'd5;
        do_arm();
        smp(32'd16, 1'b1, 5'd3, 32'd7);
        smp(32'd20, 1'b1, 5'd5, 32'h1234);
        smp(32'd24, 1'b0, 5'd0, 32'd0);
        smp(32'd28, 1'b0, 5'd0, 32'd0);
        chk("reg_a_count", 64'(a_count), 64'd4);
        pop();
        chk("reg_first_pc", 64'(a_rd_pc), 64'd16);
        pop();
        chk("reg_pc", 64'(a_rd_pc), 64'd20);
        chk("reg_rd_reg", 64'(a_rd_reg), 64'd5);
        chk("reg_rd_data", 64'(a_rd_data), 64'h1234);
        chk("reg_rd_wb_en", 64'(a_rd_wb_en), 64'd1);
        chk("reg_b_rd_data", 64'(b_rd_data), 64'h1234);

        // PC match qualified by writeback.
        do_reset();
        trig_mode = 2'b11; trig_pc = 32'd100;
        do_arm();
        smp(32'd100, 1'b0, 5'd1, 32'd1);
        chk("m11_reject_a", 64'(a_state), 64'd1);
        chk("m11_reject_b", 64'(b_state), 64'd1);
        smp(32'd104, 1'b1, 5'd1, 32'd2);
        smp(32'd100, 1'b1, 5'd1, 32'd3);
        chk("m11_fire_a", 64'(a_state), 64'd2);
        chk("m11_fire_b", 64'(b_state), 64'd2);

        // Arm beats a same-cycle pop in DONE; arm while ARMED is ignored.
        do_reset();
        trig_mode = 2'b00;
        do_arm();
        smp(32'd0, 1'b0, 5'd0, 32'd0);
        smp(32'd4, 1'b0, 5'd0, 32'd0);
        smp(32'd8, 1'b0, 5'd0, 32'd0);
        chk("ctl_b_done_count", 64'(b_count), 64'd2);
        chk("ctl_b_done_state", 64'(b_state), 64'd3);
        arm = 1'b1; rd_req = 1'b1; cycle(); arm = 1'b0; rd_req = 1'b0;
        chk("ctl_rearm_state", 64'(b_state), 64'd1);
        chk("ctl_rearm_count", 64'(b_count), 64'd0);
        chk("ctl_rearm_rd_valid", 64'(b_rd_valid), 64'd0);
        trig_mode = 2'b01; trig_pc = 32'hFFFF_FFF0;
        for (int k = 0; k < 3; k++) smp(32'(4 * k), 1'b0, 5'd0, 32'd0);
        do_arm();
        smp(32'd12, 1'b0, 5'd0, 32'd0);
        chk("ctl_arm_ignored_count", 64'(a_count), 64'd4);
        chk("ctl_arm_ignored_state", 64'(a_state), 64'd1);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            reset     = ($urandom_range(0, 399) == 0);
            arm       = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 49) == 0) trig_mode = 2'($urandom_range(0, 3));
            trig_pc   = 32'(4 * $urandom_range(0, 7));
            trig_reg  = 5'($urandom_range(0, 7));
            smp_valid = ($urandom_range(0, 9) < 6);
            smp_pc    = 32'(4 * $urandom_range(0, 15));
            smp_wb_en = 1'($urandom_range(0, 1));
            smp_reg   = 5'($urandom_range(0, 7));
            smp_data  = $urandom;
            rd_req    = ($urandom_range(0, 1) == 1);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
